// File: rtl/uart_rx_frame_timer.sv
// Oversampling frame timer for the UART receive path: tracks oversample and bit
// position within a frame and decodes sample strobes, field and done pulses.
module uart_rx_frame_timer #(
  parameter  int MAX_PRESCALE   = 32,
  parameter  int MAX_DATA_WIDTH = 9,
  localparam int PW = $clog2(MAX_PRESCALE) + 1,
  localparam int EW = $clog2(MAX_PRESCALE),
  localparam int DW = $clog2(MAX_DATA_WIDTH + 1),
  localparam int BW = $clog2(MAX_DATA_WIDTH + 5)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          enable,
  input  logic [PW-1:0] prescale,
  input  logic [DW-1:0] data_width,
  input  logic          parity_en,
  input  logic          stop2,
  output logic [EW-1:0] edge_cnt,
  output logic [BW-1:0] bit_cnt,
  output logic [1:0]    bit_field,
  output logic          sample_strobe,
  output logic          sample_last,
  output logic          bit_done,
  output logic          frame_done,
  output logic          cfg_err
);

  localparam logic [PW-1:0] MAX_P = PW'(MAX_PRESCALE);
  localparam logic [DW-1:0] MAX_N = DW'(MAX_DATA_WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q;
  logic [EW-1:0] edge_q;
  logic [BW-1:0] bit_q;
  logic [PW-1:0] p_q;
  logic [DW-1:0] n_q;
  logic          par_q;
  logic          stop2_q;

  logic          active;
  logic          cfg_legal;
  logic [PW-1:0] edge_ext;
  logic [PW-1:0] half_p;
  logic [BW-1:0] frame_len;
  logic          last_edge;
  logic          last_bit;

  assign active    = (state_q == RUN);
  assign cfg_legal = !prescale[0] && (prescale >= PW'(8)) && (prescale <= MAX_P) &&
                     (data_width >= DW'(5)) && (data_width <= MAX_N);
  assign edge_ext  = {1'b0, edge_q};
  assign half_p    = p_q >> 1;
  assign frame_len = BW'(1) + BW'(n_q) + BW'(par_q) + (stop2_q ? BW'(2) : BW'(1));
  assign last_edge = (edge_ext == p_q - PW'(1));
  assign last_bit  = (bit_q == frame_len - BW'(1));

  // The idle cycle with enable high is oversample 0, so counting resumes at 1.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      edge_q  <= '0;
      bit_q   <= '0;
      p_q     <= PW'(8);
      n_q     <= DW'(8);
      par_q   <= 1'b0;
      stop2_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable && cfg_legal) begin
            state_q <= RUN;
            edge_q  <= EW'(1);
            p_q     <= prescale;
            n_q     <= data_width;
            par_q   <= parity_en;
            stop2_q <= stop2;
          end
        end
        RUN: begin
          if (!enable) begin
            state_q <= IDLE;
            edge_q  <= '0;
            bit_q   <= '0;
          end else if (last_edge) begin
            edge_q <= '0;
            if (!last_bit) begin
              bit_q <= bit_q + BW'(1);
            end else begin
              bit_q <= '0;
              // Back-to-back frame picks up whatever configuration is presented now.
              if (cfg_legal) begin
                p_q     <= prescale;
                n_q     <= data_width;
                par_q   <= parity_en;
                stop2_q <= stop2;
              end else begin
                state_q <= IDLE;
              end
            end
          end else begin
            edge_q <= edge_q + EW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    bit_field = 2'd0;
    if (active) begin
      if (bit_q == '0)                                   bit_field = 2'd0;
      else if (bit_q <= BW'(n_q))                        bit_field = 2'd1;
      else if (par_q && (bit_q == BW'(n_q) + BW'(1)))    bit_field = 2'd2;
      else                                               bit_field = 2'd3;
    end
  end

  assign edge_cnt      = edge_q;
  assign bit_cnt       = bit_q;
  assign sample_strobe = active && ((edge_ext == half_p - PW'(1)) || (edge_ext == half_p) ||
                                    (edge_ext == half_p + PW'(1)));
  assign sample_last   = active && (edge_ext == half_p + PW'(1));
  assign bit_done      = active && last_edge;
  assign frame_done    = bit_done && last_bit;
  assign cfg_err       = !active && enable && !cfg_legal;

endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// Scoreboard bench for uart_rx_frame_timer: expected per-cycle outputs are derived
// arithmetically from the frame offset and compared when the DUT outputs settle.
module tb_uart_rx_frame_timer;

  localparam int PW = 6;
  localparam int EW = 5;
  localparam int DW = 4;
  localparam int BW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          enable = 1'b0;
  logic [PW-1:0] prescale = PW'(16);
  logic [DW-1:0] data_width = DW'(8);
  logic          parity_en = 1'b0;
  logic          stop2 = 1'b0;
  logic [EW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic [1:0]    bit_field;
  logic          sample_strobe, sample_last, bit_done, frame_done, cfg_err;

  typedef struct packed {
    logic [4:0] ec;
    logic [3:0] bc;
    logic [1:0] bf;
    logic       ss;
    logic       sl;
    logic       bd;
    logic       fd;
    logic       ce;
  } obs_t;

  obs_t sb[$];
  int   checks = 0;
  int   failures = 0;

  uart_rx_frame_timer #(.MAX_PRESCALE(32), .MAX_DATA_WIDTH(9)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .prescale(prescale),
    .data_width(data_width), .parity_en(parity_en), .stop2(stop2),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .bit_field(bit_field),
    .sample_strobe(sample_strobe), .sample_last(sample_last),
    .bit_done(bit_done), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 CLK = ~CLK;

  function automatic obs_t get_obs();
    obs_t o;
    o.ec = edge_cnt; o.bc = bit_cnt; o.bf = bit_field;
    o.ss = sample_strobe; o.sl = sample_last; o.bd = bit_done;
    o.fd = frame_done; o.ce = cfg_err;
    return o;
  endfunction

  // Expected outputs at offset k (cycles) from the first enabled cycle of a frame.
  function automatic obs_t exp_frame(int p, int n, int par, int s2, int k);
    obs_t o;
    int e, b, l;
    e = k % p;
    b = k / p;
    l = 1 + n + par + (s2 != 0 ? 2 : 1);
    o = '0;
    o.ec = 5'(e);
    o.bc = 4'(b);
    if (b == 0)                    o.bf = 2'd0;
    else if (b <= n)               o.bf = 2'd1;
    else if (par != 0 && b == n+1) o.bf = 2'd2;
    else                           o.bf = 2'd3;
    o.ss = (e >= p/2 - 1) && (e <= p/2 + 1);
    o.sl = (e == p/2 + 1);
    o.bd = (e == p - 1);
    o.fd = o.bd && (b == l - 1);
    return o;
  endfunction

  function automatic obs_t idle_obs(logic ce);
    obs_t o;
    o = '0;
    o.ce = ce;
    return o;
  endfunction

  task automatic drive(input logic en, input int p, input int n, input logic par, input logic s2);
    @(negedge CLK);
    enable = en; prescale = PW'(p); data_width = DW'(n); parity_en = par; stop2 = s2;
    #1;
  endtask

  task automatic test_reset();
    obs_t got, want;
    sb.push_back(idle_obs(1'b0));
    drive(1'b0, 16, 8, 1'b0, 1'b0);
    got = get_obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL reset_held got=%h want=%h", got, want); end
    RST = 1'b0;
    sb.push_back(idle_obs(1'b0));
    drive(1'b0, 16, 8, 1'b0, 1'b0);
    got = get_obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL reset_released got=%h want=%h", got, want); end
  endtask

  task automatic test_basic();
    obs_t got, want;
    int bd_count = 0, fd_cycle = -1;
    for (int k = 0; k < 162; k++) begin
      if (k < 161) sb.push_back(exp_frame(16, 8, 0, 0, k % 160));
      else         sb.push_back(idle_obs(1'b0));
      drive(k < 160, 16, 8, 1'b0, 1'b0);
      got = get_obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL basic k=%0d got=%h want=%h", k, got, want); end
      if (k < 160 && got.bd) bd_count++;
      if (k < 160 && got.fd) fd_cycle = k;
    end
    checks++;
    if (bd_count !== 10) begin failures++; $display("FAIL basic_bit_done_count got=%0d want=10", bd_count); end
    checks++;
    if (fd_cycle !== 159) begin failures++; $display("FAIL basic_frame_done_cycle got=%0d want=159", fd_cycle); end
  endtask

  task automatic test_back_to_back();
    obs_t got, want;
    int fd_q[$];
    for (int k = 0; k < 178; k++) begin
      if (k < 177) sb.push_back(exp_frame(8, 7, 1, 1, k % 88));
      else         sb.push_back(idle_obs(1'b0));
      drive(k < 176, 8, 7, 1'b1, 1'b1);
      got = get_obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL b2b k=%0d got=%h want=%h", k, got, want); end
      if (k < 176 && got.fd) fd_q.push_back(k);
    end
    checks++;
    if (fd_q.size() !== 2) begin
      failures++; $display("FAIL b2b_frame_done_count got=%0d want=2", fd_q.size());
    end else begin
      checks++;
      if (fd_q[0] !== 87 || fd_q[1] !== 175) begin
        failures++; $display("FAIL b2b_frame_done_cycles got=%0d,%0d want=87,175", fd_q[0], fd_q[1]);
      end
    end
  endtask

  task automatic test_midframe_change();
    obs_t got, want;
    int sl_edge17 = 0;
    for (int k = 0; k < 482; k++) begin
      if (k < 160)      sb.push_back(exp_frame(16, 8, 0, 0, k));
      else if (k < 481) sb.push_back(exp_frame(32, 8, 0, 0, (k - 160) % 320));
      else              sb.push_back(idle_obs(1'b0));
      drive(k < 480, (k >= 50) ? 32 : 16, 8, 1'b0, 1'b0);
      got = get_obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL midchange k=%0d got=%h want=%h", k, got, want); end
      if (k >= 160 && k < 480 && got.sl && got.ec == 5'd17) sl_edge17++;
    end
    checks++;
    if (sl_edge17 !== 10) begin failures++; $display("FAIL midchange_sample_last17 got=%0d want=10", sl_edge17); end
  endtask

  task automatic test_illegal_cfg();
    obs_t got, want;
    int bad_p[3] = '{13, 6, 16};
    int bad_n[3] = '{8, 8, 4};
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 3; r++) begin
        sb.push_back(idle_obs(1'b1));
        drive(1'b1, bad_p[c], bad_n[c], 1'b0, 1'b0);
        got = get_obs(); want = sb.pop_front(); checks++;
        if (got !== want) begin failures++; $display("FAIL illegal cfg=%0d r=%0d got=%h want=%h", c, r, got, want); end
      end
    end
    // Fixed config starts immediately; illegal prescale mid-frame must not raise cfg_err.
    for (int k = 0; k < 22; k++) begin
      if (k < 21) sb.push_back(exp_frame(16, 8, 0, 0, k));
      else        sb.push_back(idle_obs(1'b0));
      drive(k < 20, (k >= 5 && k <= 10) ? 13 : 16, 8, 1'b0, 1'b0);
      got = get_obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL illegal_fixed k=%0d got=%h want=%h", k, got, want); end
    end
  endtask

  task automatic test_abort();
    obs_t got, want;
    for (int k = 0; k < 71; k++) begin
      if (k < 70) sb.push_back(exp_frame(16, 8, 0, 0, k));
      else        sb.push_back(idle_obs(1'b0));
      drive(k < 69, 16, 8, 1'b0, 1'b0);
      got = get_obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL abort k=%0d got=%h want=%h", k, got, want); end
    end
    for (int k = 0; k < 22; k++) begin
      if (k < 21) sb.push_back(exp_frame(16, 8, 0, 0, k));
      else        sb.push_back(idle_obs(1'b0));
      drive(k < 20, 16, 8, 1'b0, 1'b0);
      got = get_obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL abort_restart k=%0d got=%h want=%h", k, got, want); end
    end
  endtask

  task automatic test_rst_midframe();
    obs_t got, want;
    for (int k = 0; k <= 24; k++) begin
      sb.push_back(exp_frame(8, 5, 0, 0, k));
      drive(1'b1, 8, 5, 1'b0, 1'b0);
      got = get_obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL rst_pre k=%0d got=%h want=%h", k, got, want); end
    end
    #1 RST = 1'b1;
    sb.push_back(idle_obs(1'b0));
    #1;
    got = get_obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL rst_async got=%h want=%h", got, want); end
    @(posedge CLK);
    #1 RST = 1'b0;
    for (int k = 0; k < 58; k++) begin
      if (k < 57) sb.push_back(exp_frame(8, 5, 0, 0, k % 56));
      else        sb.push_back(idle_obs(1'b0));
      drive(k < 56, 8, 5, 1'b0, 1'b0);
      got = get_obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL rst_post k=%0d got=%h want=%h", k, got, want); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_midframe_change();
    test_illegal_cfg();
    test_abort();
    test_rst_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout reached got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
